// File: rtl/instr_encoder.sv
// Packs eBPF field bundles into 64-bit instruction words; LD_IMM64 takes two output slots.
// Optional range checking of off/imm is built when ENC_RANGE_CHECK_EN is defined.
module instr_encoder #(
   parameter logic [7:0]  WIDE_OP = 8'h18,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_op,
   input  logic [3:0]       in_dst,
   input  logic [3:0]       in_src,
   input  logic [63:0]      in_off,
   input  logic [63:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             out_last,
   output logic             out_err,
   output logic [CNT_W-1:0] icount
);

   typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

   state_e           state_q, state_d;
   logic [63:0]      word0_q;
   logic [31:0]      hi_q;
   logic             wide_q;
   logic             err_q;
   logic [CNT_W-1:0] icount_q;
   logic             accept;

   assign accept = in_valid & in_ready;
   assign icount = icount_q;

   // in_ready only depends on registered state and out_ready, never on in_valid
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         StIdle:  in_ready = 1'b1;
         StLo:    in_ready = out_ready & ~wide_q;
         StHi:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) state_d = StLo;
         end
         StLo: begin
            if (out_ready) begin
               if (wide_q)      state_d = StHi;
               else if (accept) state_d = StLo;
               else             state_d = StIdle;
            end
         end
         StHi: begin
            if (out_ready) state_d = accept ? StLo : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = 64'h0;
      out_last  = 1'b0;
      out_err   = 1'b0;
      case (state_q)
         StLo: begin
            out_valid = 1'b1;
            out_data  = word0_q;
            out_last  = ~wide_q;
            out_err   = err_q;
         end
         StHi: begin
            out_valid = 1'b1;
            out_data  = {hi_q, 32'h0};
            out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   // Both halves are captured at accept so the source may move on immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word0_q <= 64'h0;
         hi_q    <= 32'h0;
         wide_q  <= 1'b0;
      end else if (accept) begin
         word0_q <= {in_imm[31:0], in_off[15:0], in_src, in_dst, in_op};
         hi_q    <= in_imm[63:32];
         wide_q  <= (in_op == WIDE_OP);
      end
   end

`ifdef ENC_RANGE_CHECK_EN
   logic off_ok, imm_ok;

   assign off_ok = (&in_off[63:15]) | ~(|in_off[63:15]);
   assign imm_ok = (&in_imm[63:31]) | ~(|in_imm[63:31]) | (in_op == WIDE_OP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= ~(off_ok & imm_ok);
      end
   end
`else
   logic unused_off;

   assign unused_off = ^in_off[63:16];
   assign err_q      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         icount_q <= '0;
      end else if (out_valid & out_ready & out_last) begin
         icount_q <= icount_q + CNT_W'(1);
      end
   end

endmodule
